// File: rtl/dmem_access_unit.sv
// Load/store unit: turns one byte-addressed hart request into a word-aligned
// valid/ready memory access and returns an extended load result or a trap.
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_funct3,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        accept, access_good, timeout;
    logic [31:0] rsp_rdata_nxt;
    logic        rsp_trap_nxt;

    function automatic logic access_ok(input logic wr, input logic [2:0] f3, input logic [1:0] lo);
        logic legal, misaligned;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~wr;
            default:                legal = 1'b0;
        endcase
        misaligned = (f3[1:0] == 2'b01 && lo[0]) || (f3[1:0] == 2'b10 && lo != 2'b00);
        return legal && !misaligned;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {24'b0, wd[7:0]} << {lo, 3'b000};
            2'b01:   return lo[1] ? {wd[15:0], 16'b0} : {16'b0, wd[15:0]};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] rd);
        logic [31:0] b_sh, h_sh;
        b_sh = rd >> {lo, 3'b000};
        h_sh = rd >> {lo[1], 4'b0000};
        case (f3)
            3'b000:  return {{24{b_sh[7]}}, b_sh[7:0]};
            3'b001:  return {{16{h_sh[15]}}, h_sh[15:0]};
            3'b100:  return {24'b0, b_sh[7:0]};
            3'b101:  return {16'b0, h_sh[15:0]};
            default: return rd;
        endcase
    endfunction

    assign accept      = (state == IDLE) && i_req_valid;
    assign access_good = access_ok(i_req_write, i_req_funct3, i_req_addr[1:0]);
    assign timeout     = (cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req_valid) state_nxt = access_good ? REQ : RESP;
            REQ:     if (i_mem_ready) state_nxt = write_q ? RESP : WAIT;
            WAIT:    if (i_mem_rvalid || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state == IDLE) && !i_rst;
        o_mem_valid = (state == REQ);
        o_mem_ren   = o_mem_valid && !write_q;
        o_mem_wen   = o_mem_valid && write_q;
        o_rsp_valid = (state == RESP);
    end

    // Response fields are only non-zero during the RESP cycle; rvalid beats the timeout.
    always_comb begin
        rsp_rdata_nxt = '0;
        rsp_trap_nxt  = 1'b0;
        if (state == WAIT && i_mem_rvalid)
            rsp_rdata_nxt = load_extend(funct3_q, addr_lo_q, i_mem_rdata);
        if ((accept && !access_good) || (state == WAIT && !i_mem_rvalid && timeout))
            rsp_trap_nxt = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt         <= '0;
            o_mem_addr  <= '0;
            o_mem_mask  <= '0;
            o_mem_wdata <= '0;
            o_rsp_rdata <= '0;
            o_rsp_trap  <= 1'b0;
        end else begin
            cnt         <= (state == WAIT) ? cnt + 16'd1 : '0;
            o_rsp_rdata <= rsp_rdata_nxt;
            o_rsp_trap  <= rsp_trap_nxt;
            if (accept && access_good) begin
                o_mem_addr  <= {i_req_addr[31:2], 2'b00};
                o_mem_mask  <= lane_mask(i_req_funct3, i_req_addr[1:0]);
                o_mem_wdata <= lane_wdata(i_req_funct3, i_req_addr[1:0], i_req_wdata);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            write_q   <= i_req_write;
            funct3_q  <= i_req_funct3;
            addr_lo_q <= i_req_addr[1:0];
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: drives hart requests and a scripted
// memory, scoreboards responses and checks handshake timing cycle by cycle.
module tb_dmem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0, rst = 1'b0;
    logic        i_req_valid = 1'b0, i_req_write = 1'b0;
    logic [31:0] i_req_addr = '0, i_req_wdata = '0;
    logic [2:0]  i_req_funct3 = '0;
    logic        i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_req_ready, o_rsp_valid, o_rsp_trap;
    logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
    logic        o_mem_valid, o_mem_ren, o_mem_wen;
    logic [3:0]  o_mem_mask;

    typedef struct packed {
        logic [31:0] rdata;
        logic        trap;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0, n_err = 0;

    dmem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_funct3(i_req_funct3),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_trap(o_rsp_trap),
        .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
        .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .o_mem_mask(o_mem_mask), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Response monitor: every rsp pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mem_rsp_overlap", {31'b0, o_mem_valid & o_rsp_valid}, 32'd0);
            chk("ren_wen_overlap", {31'b0, o_mem_ren & o_mem_wen}, 32'd0);
        end
        if (o_rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {31'b0, o_rsp_valid}, 32'd0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", o_rsp_rdata, e.rdata);
                chk("rsp_trap", {31'b0, o_rsp_trap}, {31'b0, e.trap});
            end
        end
    end

    // rv_dly < 0: memory never returns data. early: trap decided in IDLE.
    task automatic access(input string name, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int rdy_dly, input int rv_dly, input logic [31:0] mrd,
                          input logic [31:0] exp_rd, input logic exp_trap, input logic early,
                          input logic [3:0] exp_mask, input logic [31:0] exp_wd);
        int lat, n_wait;
        chk({name, "_req_ready"}, {31'b0, o_req_ready}, 32'd1);
        i_req_valid  = 1'b1;
        i_req_write  = wr;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        i_req_funct3 = f3;
        sb.push_back(rsp_t'{rdata: exp_rd, trap: exp_trap});
        @(negedge clk);
        i_req_valid  = 1'b0;
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;
        lat = 1;
        if (!early) begin
            for (int i = 0; i <= rdy_dly; i++) begin
                chk({name, "_mem_valid"}, {31'b0, o_mem_valid}, 32'd1);
                chk({name, "_mem_ren"}, {31'b0, o_mem_ren}, {31'b0, ~wr});
                chk({name, "_mem_wen"}, {31'b0, o_mem_wen}, {31'b0, wr});
                chk({name, "_mem_addr"}, o_mem_addr, {addr[31:2], 2'b00});
                chk({name, "_mem_mask"}, {28'b0, o_mem_mask}, {28'b0, exp_mask});
                if (wr) chk({name, "_mem_wdata"}, o_mem_wdata, exp_wd);
                chk({name, "_no_early_rsp"}, {31'b0, o_rsp_valid}, 32'd0);
                i_mem_ready = (i == rdy_dly);
                @(negedge clk);
                lat++;
            end
            i_mem_ready = 1'b0;
            if (!wr) begin
                n_wait = (rv_dly < 0) ? TO : rv_dly + 1;
                for (int j = 0; j < n_wait; j++) begin
                    chk({name, "_wait_mem_valid"}, {31'b0, o_mem_valid}, 32'd0);
                    chk({name, "_wait_rsp"}, {31'b0, o_rsp_valid}, 32'd0);
                    i_mem_rvalid = (rv_dly >= 0) && (j == rv_dly);
                    i_mem_rdata  = mrd;
                    @(negedge clk);
                    lat++;
                end
                i_mem_rvalid = 1'b0;
                i_mem_rdata  = $urandom;
            end
        end
        chk($sformatf("%s_rsp_at_lat%0d", name, lat), {31'b0, o_rsp_valid}, 32'd1);
        chk({name, "_rsp_mem_valid"}, {31'b0, o_mem_valid}, 32'd0);
        @(negedge clk);
        chk({name, "_rsp_one_cycle"}, {31'b0, o_rsp_valid}, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", {31'b0, o_req_ready}, 32'd0);
        chk("rst_mem_valid", {31'b0, o_mem_valid}, 32'd0);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'd0);
        chk("rst_mem_mask", {28'b0, o_mem_mask}, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_rsp_trap", {31'b0, o_rsp_trap}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        access("lb",     1'b0, 3'b000, 32'h1003, 32'h0,        1, 1, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 1'b0, 4'b1000, 32'h0);
        access("lhu",    1'b0, 3'b101, 32'h2002, 32'h0,        0, 0, 32'hBEEF0000, 32'h0000BEEF, 1'b0, 1'b0, 4'b1100, 32'h0);
        access("lh",     1'b0, 3'b001, 32'h2002, 32'h0,        0, 2, 32'hBEEF0000, 32'hFFFFBEEF, 1'b0, 1'b0, 4'b1100, 32'h0);
        access("lbu",    1'b0, 3'b100, 32'h1002, 32'h0,        0, 0, 32'h80FF1234, 32'h000000FF, 1'b0, 1'b0, 4'b0100, 32'h0);
        access("sb",     1'b1, 3'b000, 32'h3001, 32'h000000AB, 5, 0, 32'h0,        32'h0,        1'b0, 1'b0, 4'b0010, 32'h0000AB00);
        access("sh",     1'b1, 3'b001, 32'h3002, 32'hCAFEBABE, 1, 0, 32'h0,        32'h0,        1'b0, 1'b0, 4'b1100, 32'hBABE0000);
        access("lw_mis", 1'b0, 3'b010, 32'h4002, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1'b1, 4'b0000, 32'h0);
        access("f3_011", 1'b0, 3'b011, 32'h4000, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1'b1, 4'b0000, 32'h0);
        access("st_f3u", 1'b1, 3'b100, 32'h4000, 32'h55,       0, 0, 32'h0,        32'h0,        1'b1, 1'b1, 4'b0000, 32'h0);
        access("lh_mis", 1'b0, 3'b001, 32'h4001, 32'h0,        0, 0, 32'h0,        32'h0,        1'b1, 1'b1, 4'b0000, 32'h0);
        access("lw_to",  1'b0, 3'b010, 32'h4000, 32'h0,        0, -1, 32'h0,       32'h0,        1'b1, 1'b0, 4'b1111, 32'h0);

        // Late rvalid while idle must be ignored
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        chk("late_rvalid_no_rsp", {31'b0, o_rsp_valid}, 32'd0);
        chk("late_rvalid_ready", {31'b0, o_req_ready}, 32'd1);

        access("lw_edge", 1'b0, 3'b010, 32'h4004, 32'h0, 0, TO - 1, 32'h11223344, 32'h11223344, 1'b0, 1'b0, 4'b1111, 32'h0);

        // Reset while a load sits in WAIT
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = 32'h6000; i_req_funct3 = 3'b010;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("rw_mem_valid", {31'b0, o_mem_valid}, 32'd1);
        i_mem_ready = 1'b1;
        @(negedge clk);
        i_mem_ready = 1'b0;
        chk("rw_in_wait", {31'b0, o_mem_valid}, 32'd0);
        chk("rw_busy", {31'b0, o_req_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("rw_mem_valid_rst", {31'b0, o_mem_valid}, 32'd0);
        chk("rw_mem_ren_rst", {31'b0, o_mem_ren}, 32'd0);
        chk("rw_rsp_valid_rst", {31'b0, o_rsp_valid}, 32'd0);
        chk("rw_mem_addr_rst", o_mem_addr, 32'd0);
        chk("rw_mem_mask_rst", {28'b0, o_mem_mask}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        i_mem_rvalid = 1'b1;
        #1;
        chk("rw_ready_after", {31'b0, o_req_ready}, 32'd1);
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        chk("rw_stale_rvalid", {31'b0, o_rsp_valid}, 32'd0);

        // Reset while a store is presented to memory
        i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 32'h7000; i_req_funct3 = 3'b010;
        @(negedge clk);
        i_req_valid = 1'b0;
        chk("rq_mem_wen", {31'b0, o_mem_wen}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rq_mem_valid_rst", {31'b0, o_mem_valid}, 32'd0);
        chk("rq_mem_wen_rst", {31'b0, o_mem_wen}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        access("sw", 1'b1, 3'b010, 32'h5000, 32'h12345678, 2, 0, 32'h0, 32'h0, 1'b0, 1'b0, 4'b1111, 32'h12345678);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
